pcie_lane_scrambler: RTL and testbench

- Gen1/Gen2 PCIe lane scrambler for the 2-symbol-per-clock 8b/10b datapath.
- Sits between the soft endpoint TX output and the GTP TX fabric interface: consumes the endpoint's tx_data/tx_charisk and drives the GTP tx_data/tx_charisk.
- Applies the PCIe LFSR scrambling to data symbols and leaves K symbols and training-sequence payloads unscrambled.
- Because XOR scrambling is symmetric, the same block is instantiated as the RX descrambler, GTP RX → endpoint.

---
 rtl/pcie_lane_scrambler.sv | 127 ++++++++++++
 tb/tb_pcie_lane_scrambler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_lane_scrambler.sv
// PCIe Gen1/Gen2 lane scrambler/descrambler for a 2-symbol-per-clock 8b/10b datapath.
// K symbols and TS1/TS2 payloads pass unscrambled; COM reseeds the LFSR.
module pcie_lane_scrambler #(
  parameter logic [15:0] SEED   = 16'hFFFF,
  parameter int          TS_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scramble_disable,
  input  logic [15:0] din,
  input  logic [1:0]  din_charisk,
  output logic [15:0] dout,
  output logic [1:0]  dout_charisk
);

  localparam int CW_RAW = $clog2(TS_LEN + 1);
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;
  localparam logic [CW-1:0] TS_LAST = CW'(TS_LEN - 1);

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] PAD = 8'hF7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    AFTER_COM = 2'd1,
    SKP_OS    = 2'd2,
    TS        = 2'd3
  } os_state_t;

  typedef struct packed {
    logic [15:0]   lfsr;
    os_state_t     st;
    logic [CW-1:0] cnt;
    logic [7:0]    sym;
  } lane_t;

  // Eight Galois shifts; returns {scramble byte (first output bit in bit 0), new LFSR}.
  function automatic logic [23:0] advance(input logic [15:0] s_in);
    logic [15:0] s;
    logic [7:0]  b;
    s = s_in;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b[i] = s[15];
      s    = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    end
    return {b, s};
  endfunction

  function automatic lane_t lane_step(input lane_t cur, input logic [7:0] sym,
                                      input logic is_k, input logic bypass);
    lane_t         nxt;
    logic [23:0]   adv;
    logic          is_com;
    logic          is_skp;
    logic          ts_sym;
    logic          normal;
    logic [CW-1:0] next_cnt;
    adv      = advance(cur.lfsr);
    is_com   = is_k && (sym == COM);
    is_skp   = is_k && (sym == SKP);
    ts_sym   = 1'b0;
    normal   = 1'b0;
    nxt      = cur;
    nxt.sym  = sym;
    case (cur.st)
      AFTER_COM: begin
        ts_sym = !is_k || (sym == PAD);
        normal = is_k && (sym != PAD) && !is_skp;
      end
      SKP_OS:  normal = !is_skp;
      TS:      ts_sym = !is_skp;
      default: normal = 1'b1;
    endcase
    next_cnt = ((cur.st == TS) ? cur.cnt : {CW{1'b0}}) + CW'(1);
    if (is_com) begin
      nxt.lfsr = SEED;
      nxt.st   = AFTER_COM;
      nxt.cnt  = {CW{1'b0}};
    end else if (ts_sym) begin
      nxt.lfsr = adv[15:0];
      nxt.st   = (next_cnt >= TS_LAST) ? IDLE : TS;
      nxt.cnt  = (next_cnt >= TS_LAST) ? {CW{1'b0}} : next_cnt;
    end else if (normal) begin
      nxt.st   = IDLE;
      nxt.lfsr = is_skp ? cur.lfsr : adv[15:0];
      nxt.sym  = (is_k || bypass) ? sym : (sym ^ adv[23:16]);
    end else begin
      // Only SKPs reach here: they hold the LFSR and open a SKP ordered set after COM.
      nxt.st = (cur.st == AFTER_COM) ? SKP_OS : cur.st;
    end
    return nxt;
  endfunction

  logic [15:0]   lfsr_r;
  os_state_t     state_r;
  logic [CW-1:0] cnt_r;
  lane_t         cur_s;
  lane_t         lane0_s;
  lane_t         lane1_s;

  // Lane 1 continues from the state lane 0 leaves behind.
  always_comb begin
    cur_s     = '{lfsr: lfsr_r, st: state_r, cnt: cnt_r, sym: 8'h00};
    lane0_s   = lane_step(cur_s, din[7:0], din_charisk[0], scramble_disable);
    lane1_s   = lane_step(lane0_s, din[15:8], din_charisk[1], scramble_disable);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r       <= SEED;
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      dout         <= 16'h0000;
      dout_charisk <= 2'b00;
    end else begin
      lfsr_r       <= lane1_s.lfsr;
      state_r      <= lane1_s.st;
      cnt_r        <= lane1_s.cnt;
      dout         <= {lane1_s.sym, lane0_s.sym};
      dout_charisk <= din_charisk;
    end
  end

endmodule

// File: tb/tb_pcie_lane_scrambler.sv
// Self-checking bench for pcie_lane_scrambler: directed spec scenarios plus
// randomized symbol streams against an ordered-set-level reference model.
module tb_pcie_lane_scrambler;

  localparam int TS_LEN = 16;
  localparam int M_IDLE = 0, M_AFTER = 1, M_SKP = 2, M_TS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        scramble_disable;
  logic [15:0] din;
  logic [1:0]  din_charisk;
  logic [15:0] dout;
  logic [1:0]  dout_charisk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  seq [4096];
  int          m_idx, m_mode, m_ts_left;
  logic [15:0] exp_dout;
  logic [1:0]  exp_k;

  pcie_lane_scrambler #(.SEED(16'hFFFF), .TS_LEN(TS_LEN)) dut (
    .clk(clk), .rst(rst), .scramble_disable(scramble_disable),
    .din(din), .din_charisk(din_charisk),
    .dout(dout), .dout_charisk(dout_charisk)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scramble sequence from the seed: multiply by x modulo G(x), output the x^15 coefficient.
  task automatic build_seq();
    int unsigned st;
    logic [7:0] b;
    st = 32'h0000FFFF;
    for (int n = 0; n < 4096; n++) begin
      for (int i = 0; i < 8; i++) begin
        b[i] = st[15];
        st = st << 1;
        if (st[16]) st = st ^ 32'h00010039;
      end
      seq[n] = b;
    end
  endtask

  task automatic model_sym(input logic [7:0] b, input logic k, input logic dis,
                           output logic [7:0] o);
    bit com, skp;
    com = k && (b == 8'hBC);
    skp = k && (b == 8'h1C);
    o = b;
    if (com) begin
      m_idx = 0;
      m_mode = M_AFTER;
    end else if (m_mode == M_AFTER && skp) begin
      m_mode = M_SKP;
    end else if (m_mode == M_AFTER && (!k || b == 8'hF7)) begin
      m_idx++;
      m_ts_left = TS_LEN - 2;
      m_mode = (m_ts_left > 0) ? M_TS : M_IDLE;
    end else if (m_mode == M_TS) begin
      if (!skp) begin
        m_idx++;
        m_ts_left--;
        if (m_ts_left == 0) m_mode = M_IDLE;
      end
    end else if (!skp) begin
      m_mode = M_IDLE;
      if (!k && !dis) o = b ^ seq[m_idx];
      m_idx++;
    end
  endtask

  task automatic drive_pair(input logic [15:0] d, input logic [1:0] k, input logic dis);
    logic [7:0] o0, o1;
    model_sym(d[7:0], k[0], dis, o0);
    model_sym(d[15:8], k[1], dis, o1);
    exp_dout = {o1, o0};
    exp_k = k;
    din = d;
    din_charisk = k;
    scramble_disable = dis;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 16'h0000;
    din_charisk = 2'b00;
    scramble_disable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_idx = 0;
    m_mode = M_IDLE;
    m_ts_left = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dout !== 16'h0000 || dout_charisk !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %h/%b want 0000/00", dout, dout_charisk);
    end
    drive_pair(16'h0000, 2'b00, 1'b0);
    checks++;
    if (dout !== 16'h17FF) begin
      errors++;
      $display("FAIL reset_first_data: got %h want 17FF", dout);
    end
    drive_pair(16'hFBFD, 2'b11, 1'b0);
    checks++;
    if (dout !== 16'hFBFD || dout_charisk !== 2'b11) begin
      errors++;
      $display("FAIL k_pair: got %h/%b want FBFD/11", dout, dout_charisk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 16'h0000 || dout_charisk !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got %h/%b want 0000/00", dout, dout_charisk);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_idx = 0; m_mode = M_IDLE; m_ts_left = 0;
    drive_pair(16'h0000, 2'b00, 1'b0);
    checks++;
    if (dout !== 16'h17FF) begin
      errors++;
      $display("FAIL reset_reseed: got %h want 17FF", dout);
    end
  endtask

  task automatic test_com_zeros();
    logic [15:0] d [4];
    logic [1:0]  k [4];
    logic [15:0] ed [4];
    d  = '{16'h00BC, 16'h1CBC, 16'h0000, 16'h0000};
    k  = '{2'b01, 2'b11, 2'b00, 2'b00};
    ed = '{16'h00BC, 16'h1CBC, 16'h17FF, 16'h14C0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_pair(d[i], k[i], 1'b0);
      checks++;
      if (dout !== ed[i] || dout_charisk !== k[i]) begin
        errors++;
        $display("FAIL com_zeros[%0d]: got %h/%b want %h/%b", i, dout, dout_charisk, ed[i], k[i]);
      end
    end
  endtask

  task automatic test_lane1_com();
    logic [15:0] d [3];
    logic [1:0]  k [3];
    logic [15:0] ed [3];
    d  = '{16'h0000, 16'hBC00, 16'h001C};
    k  = '{2'b00, 2'b10, 2'b01};
    ed = '{16'h17FF, 16'hBCC0, 16'hFF1C};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_pair(d[i], k[i], 1'b0);
      checks++;
      if (dout !== ed[i] || dout_charisk !== k[i]) begin
        errors++;
        $display("FAIL lane1_com[%0d]: got %h/%b want %h/%b", i, dout, dout_charisk, ed[i], k[i]);
      end
    end
  endtask

  task automatic test_skp_os();
    logic [15:0] d [3];
    logic [1:0]  k [3];
    logic [15:0] ed [3];
    d  = '{16'h1CBC, 16'h1C1C, 16'h0000};
    k  = '{2'b11, 2'b11, 2'b00};
    ed = '{16'h1CBC, 16'h1C1C, 16'h17FF};
    do_reset();
    drive_pair(16'h0000, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_pair(d[i], k[i], 1'b0);
      checks++;
      if (dout !== ed[i] || dout_charisk !== k[i]) begin
        errors++;
        $display("FAIL skp_os[%0d]: got %h/%b want %h/%b", i, dout, dout_charisk, ed[i], k[i]);
      end
    end
  endtask

  task automatic test_ts1();
    logic [15:0] want;
    do_reset();
    drive_pair(16'hF7BC, 2'b11, 1'b0);
    checks++;
    if (dout !== 16'hF7BC || dout_charisk !== 2'b11) begin
      errors++;
      $display("FAIL ts1_head: got %h/%b want F7BC/11", dout, dout_charisk);
    end
    for (int i = 0; i < 7; i++) begin
      drive_pair(16'h4A4A, 2'b00, 1'b0);
      checks++;
      if (dout !== 16'h4A4A) begin
        errors++;
        $display("FAIL ts1_payload[%0d]: got %h want 4A4A", i, dout);
      end
    end
    want = {seq[16], seq[15]};
    drive_pair(16'h0000, 2'b00, 1'b0);
    checks++;
    if (dout !== want) begin
      errors++;
      $display("FAIL ts1_after: got %h want %h", dout, want);
    end
  endtask

  task automatic test_truncated_ts();
    logic [15:0] d [4];
    logic [1:0]  k [4];
    logic [15:0] ed [4];
    d  = '{16'h01BC, 16'h4A4A, 16'h3CBC, 16'h0000};
    k  = '{2'b01, 2'b00, 2'b11, 2'b00};
    ed = '{16'h01BC, 16'h4A4A, 16'h3CBC, 16'hC017};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_pair(d[i], k[i], 1'b0);
      checks++;
      if (dout !== ed[i] || dout_charisk !== k[i]) begin
        errors++;
        $display("FAIL truncated_ts[%0d]: got %h/%b want %h/%b", i, dout, dout_charisk, ed[i], k[i]);
      end
    end
  endtask

  task automatic test_scramble_disable();
    logic [15:0] d [3];
    logic [1:0]  k [3];
    logic        dis [3];
    logic [15:0] ed [3];
    d   = '{16'h1CBC, 16'h0000, 16'h0000};
    k   = '{2'b11, 2'b00, 2'b00};
    dis = '{1'b1, 1'b1, 1'b0};
    ed  = '{16'h1CBC, 16'h0000, 16'h14C0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_pair(d[i], k[i], dis[i]);
      checks++;
      if (dout !== ed[i] || dout_charisk !== k[i]) begin
        errors++;
        $display("FAIL scramble_disable[%0d]: got %h/%b want %h/%b", i, dout, dout_charisk, ed[i], k[i]);
      end
    end
  endtask

  task automatic rand_sym(output logic [7:0] b, output logic k);
    int r;
    r = $urandom_range(0, 99);
    k = 1'b1;
    if (r < 55)      begin b = 8'($urandom_range(0, 255)); k = 1'b0; end
    else if (r < 63) b = 8'hBC;
    else if (r < 71) b = 8'h1C;
    else if (r < 76) b = 8'h3C;
    else if (r < 80) b = 8'h7C;
    else if (r < 86) b = 8'hF7;
    else if (r < 92) b = ($urandom_range(0, 1) == 0) ? 8'hFB : 8'hFD;
    else             begin b = 8'h4A; k = 1'b0; end
  endtask

  task automatic test_random();
    logic [7:0] b0, b1;
    logic       k0, k1;
    logic       dis;
    dis = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      for (int n = 0; n < 250; n++) begin
        rand_sym(b0, k0);
        rand_sym(b1, k1);
        if ($urandom_range(0, 19) == 0) dis = !dis;
        drive_pair({b1, b0}, {k1, k0}, dis);
        checks++;
        if (dout !== exp_dout || dout_charisk !== exp_k) begin
          errors++;
          $display("FAIL random[%0d.%0d]: got %h/%b want %h/%b", seg, n, dout, dout_charisk, exp_dout, exp_k);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 16'h0000;
    din_charisk = 2'b00;
    scramble_disable = 1'b0;
    build_seq();
    @(posedge clk); #1;
    test_reset();
    test_com_zeros();
    test_lane1_com();
    test_skp_os();
    test_ts1();
    test_truncated_ts();
    test_scramble_disable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
